fdiv_seq: RTL and testbench

Iterative IEEE-754 single-precision divider (quotient = a / b), the inverse operation of the combinational fmult block. Uses restoring radix-2 mantissa division, one quotient bit per clock. A start/busy/done handshake lets the FPU datapath issue a divide and collect the result. Rounding, denormal and NaN conventions match fmult: truncation toward zero, flush-to-zero, canonical quiet NaN.

---
 rtl/fdiv_seq.sv | 175 +++++++++++++++++
 tb/tb_fdiv_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// fdiv_seq: iterative IEEE-754 single-precision divider, quotient = a / b.
// Restoring radix-2 mantissa division, one quotient bit per clock.
// Truncating rounding, flush-to-zero on denormal inputs and underflow,
// canonical quiet NaN on any invalid result.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   divide request, sampled only while idle
//   a, b    dividend / divisor, sampled on the accepting edge
//   busy    high while a divide is in flight
//   done    one-cycle pulse, result valid
//   result  quotient, held until the next completion
//
// state | meaning
// IDLE  | waiting for start; specials resolve here in one cycle
// DIV   | 25 restoring-division steps, one quotient bit per clock
// NORM  | normalise quotient, range-check exponent, write result
module fdiv_seq #(
    parameter logic [31:0] QNAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [24:0] r_rem;
    logic [23:0] r_div;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic [9:0]  r_exp;
    logic [31:0] r_result;
    logic        r_done;

    // operand classification
    logic        w_a_zero, w_a_inf, w_a_nan;
    logic        w_b_zero, w_b_inf, w_b_nan;
    logic        w_sign;
    logic [9:0]  w_exp_init;
    logic        w_special;
    logic [31:0] w_special_res;

    assign w_a_zero = (a[30:23] == 8'h00);
    assign w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    assign w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    assign w_b_zero = (b[30:23] == 8'h00);
    assign w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    assign w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);

    assign w_sign = a[31] ^ b[31];
    // two's-complement wrap in 10 bits gives the signed biased exponent
    assign w_exp_init = {2'b00, a[30:23]} - {2'b00, b[30:23]} + 10'd127;

    always_comb begin
        w_special     = 1'b1;
        w_special_res = 32'h0;
        if (w_a_nan || w_b_nan) begin
            w_special_res = QNAN;
        end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_special_res = QNAN;
        end else if (w_a_inf || (!w_a_zero && w_b_zero)) begin
            w_special_res = {w_sign, 8'hFF, 23'h0};
        end else if (w_b_inf || w_a_zero) begin
            w_special_res = 32'h0;
        end else begin
            w_special = 1'b0;
        end
    end

    // restoring division step
    logic        w_rem_ge;
    logic [24:0] w_rem_diff;
    logic [24:0] w_rem_nxt;

    assign w_rem_ge   = (r_rem >= {1'b0, r_div});
    assign w_rem_diff = w_rem_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    // partial remainder is always below the divisor here, so the shift cannot overflow
    assign w_rem_nxt  = w_rem_diff << 1;

    // normalisation: quotient lies in [0.5, 2), q[24] marks the >= 1 case
    logic signed [9:0] w_norm_exp;
    logic [22:0]       w_norm_mant;
    logic [31:0]       w_norm_res;

    assign w_norm_exp  = r_q[24] ? r_exp : (r_exp - 10'd1);
    assign w_norm_mant = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_comb begin
        w_norm_res = {r_sign, w_norm_exp[7:0], w_norm_mant};
        if (w_norm_exp >= 10'sd255) begin
            w_norm_res = {r_sign, 8'hFF, 23'h0};
        end else if (w_norm_exp <= 10'sd0) begin
            w_norm_res = 32'h0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (start && !w_special) w_state_nxt = DIV;
            DIV:  if (r_cnt == 5'd24)      w_state_nxt = NORM;
            NORM:                          w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= 25'h0;
            r_div    <= 24'h0;
            r_q      <= 25'h0;
            r_cnt    <= 5'd0;
            r_sign   <= 1'b0;
            r_exp    <= 10'h0;
            r_result <= 32'h0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= w_sign;
                        r_exp  <= w_exp_init;
                        r_rem  <= {2'b01, a[22:0]};
                        r_div  <= {1'b1, b[22:0]};
                        r_q    <= 25'h0;
                        r_cnt  <= 5'd0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= {r_q[23:0], w_rem_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                NORM: begin
                    r_result <= w_norm_res;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_fdiv_seq.sv
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    fdiv_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    // scoreboard: every done pulse pops one expected quotient
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_done result=%h no expected value queued", result);
            end else begin
                mon_exp = sb.pop_front();
                if (result !== mon_exp)
                    $display("FAIL result got=%h want=%h", result, mon_exp);
                else
                    n_pass++;
            end
        end
    end

    // drive one request; returns at the negedge right after the accepting edge
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] iexp, input bit push);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        if (push) sb.push_back(iexp);
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // k = edges after the accepting edge at which done is observed
    task automatic wait_done(input int k0, output int k, output int busy_n);
        k = k0;
        busy_n = 0;
        while (!done && k < 60) begin
            if (busy) busy_n++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done); else n_pass++;
        n_checks++; if (result !== 32'h0) $display("FAIL reset_result got=%h want=00000000", result); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int k, bn, d0;
        d0 = done_cnt;
        issue(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
        wait_done(0, k, bn);
        n_checks++; if (k !== 26) $display("FAIL basic_latency got=%0d want=26", k); else n_pass++;
        n_checks++; if (bn !== 26) $display("FAIL basic_busy_cycles got=%0d want=26", bn); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (result !== 32'h4040_0000) $display("FAIL basic_hold got=%h want=40400000", result); else n_pass++;
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy got=%b want=0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int k, bn;
        issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b1);
        wait_done(0, k, bn);
        n_checks++; if (k !== 26) $display("FAIL b2b_first_latency got=%0d want=26", k); else n_pass++;
        // issue in the done cycle itself
        a = 32'hC100_0000;
        b = 32'h3F00_0000;
        start = 1'b1;
        sb.push_back(32'hC180_0000);
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_accept_busy got=%b want=1", busy); else n_pass++;
        wait_done(0, k, bn);
        n_checks++; if (k !== 26) $display("FAIL b2b_second_latency got=%0d want=26", k); else n_pass++;
        @(negedge clk);
    endtask

    logic [31:0] sp_a[9] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000,
                             32'h7F80_0000, 32'hC152_6666, 32'h7F00_0000, 32'h0080_0000,
                             32'h0040_0000};
    logic [31:0] sp_b[9] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h7F80_000D,
                             32'hFF80_0000, 32'h7F80_0000, 32'h3E80_0000, 32'h4000_0000,
                             32'h3F80_0000};
    logic [31:0] sp_e[9] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000,
                             32'h7FC0_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000,
                             32'h0000_0000};
    int          sp_k[9] = '{0, 0, 0, 0, 0, 0, 26, 26, 0};

    task automatic test_specials_and_range();
        int k, bn;
        for (int i = 0; i < 9; i++) begin
            issue(sp_a[i], sp_b[i], sp_e[i], 1'b1);
            wait_done(0, k, bn);
            n_checks++;
            if (k !== sp_k[i])
                $display("FAIL special_latency[%0d] got=%0d want=%0d", i, k, sp_k[i]);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int k, bn, d0;
        d0 = done_cnt;
        issue(32'h4234_851F, 32'h3F80_0000, 32'h4234_851F, 1'b1);
        repeat (9) @(negedge clk);
        a = 32'h4100_0000;
        b = 32'h4000_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(10, k, bn);
        n_checks++; if (k !== 26) $display("FAIL ignore_latency got=%0d want=26", k); else n_pass++;
        repeat (30) @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 1) $display("FAIL ignore_done_count got=%0d want=1", done_cnt - d0); else n_pass++;
        n_checks++; if (result !== 32'h4234_851F) $display("FAIL ignore_hold got=%h want=4234851f", result); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int d0;
        issue(32'h40C0_0000, 32'h4000_0000, 32'h0, 1'b0);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL abort_done got=%b want=0", done); else n_pass++;
        n_checks++; if (result !== 32'h0) $display("FAIL abort_result got=%h want=00000000", result); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 0) $display("FAIL abort_no_done got=%0d want=0", done_cnt - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_idle got=%b want=0", busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_specials_and_range();
        test_ignore_start();
        test_reset_abort();
        n_checks++;
        if (sb.size() !== 0)
            $display("FAIL scoreboard_drain got=%0d pending want=0", sb.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
